stream_fifo: RTL and testbench

Parametrised elastic buffer for the stb/ack streaming interface used between the file readers, the floating-point operators and the file writer. It decouples a producer from a consumer so that multi-cycle operators such as the double divider can be fed back-to-back without stalling the source. It also reports live occupancy and a peak-occupancy statistic for throughput debugging in test benches. It is a drop-in insert on any 64-bit (or other WIDTH) stb/ack link.

---
 rtl/stream_fifo_if.sv | 34 +++
 rtl/stream_fifo.sv | 90 +++++++++
 tb/tb_stream_fifo.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/stream_fifo_if.sv
// stream_fifo_if: stb/ack streaming link carrying one producer->FIFO path and
// one FIFO->consumer path.
//   input_a / input_a_stb / input_a_ack    : write side (producer to FIFO)
//   output_z / output_z_stb / output_z_ack : read side (FIFO to consumer)
// Modport slave is the FIFO's view; modport master is the environment's view
// (producer and consumer together).
interface stream_fifo_if #(
    parameter int unsigned WIDTH = 64
);
    logic [WIDTH-1:0] input_a;
    logic             input_a_stb;
    logic             input_a_ack;
    logic [WIDTH-1:0] output_z;
    logic             output_z_stb;
    logic             output_z_ack;

    modport master (
        output input_a,
        output input_a_stb,
        input  input_a_ack,
        input  output_z,
        input  output_z_stb,
        output output_z_ack
    );

    modport slave (
        input  input_a,
        input  input_a_stb,
        output input_a_ack,
        output output_z,
        output output_z_stb,
        input  output_z_ack
    );
endinterface

// File: rtl/stream_fifo.sv
// stream_fifo: elastic buffer for a stb/ack stream, with live and peak
// occupancy reporting.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   flush     : synchronous clear of pointers, occupancy and peak statistic
//   bus       : stream_fifo_if.slave (input_a*, output_z*)
//   count     : current occupancy, 0..DEPTH
//   max_count : peak occupancy since reset or flush
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module stream_fifo #(
    parameter  int unsigned WIDTH = 64,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    stream_fifo_if.slave  bus,
    output logic [CW-1:0] count,
    output logic [CW-1:0] max_count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt_c;
    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;

    // Handshake flags depend only on registered occupancy and flush, so there
    // is no combinational path from stb/ack on one side to the other side.
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == '0);

    assign bus.input_a_ack  = !full_c && !flush;
    assign bus.output_z_stb = !empty_c && !flush;
    assign bus.output_z     = mem[rd_ptr];

    assign push_c = bus.input_a_stb  && bus.input_a_ack;
    assign pop_c  = bus.output_z_stb && bus.output_z_ack;

    // Next occupancy; push and pop together leave it unchanged.
    always_comb begin
        count_nxt_c = count;
        if (flush) begin
            count_nxt_c = '0;
        end else if (push_c && !pop_c) begin
            count_nxt_c = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt_c = count - CW'(1);
        end
    end

    // Pointers, occupancy and peak statistic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else begin
            count <= count_nxt_c;
            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                max_count <= '0;
            end else begin
                if (push_c) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                if (count_nxt_c > max_count) begin
                    max_count <= count_nxt_c;
                end
            end
        end
    end

    // Storage array; contents survive reset and flush, only pointers move.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= bus.input_a;
        end
    end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: table-driven check of stream_fifo (WIDTH=64, DEPTH=8) plus
// hand-written reset sequences.
module tb_stream_fifo;
    localparam int unsigned WIDTH = 64;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    localparam logic [63:0] D_BASE = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] E_BASE = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F_BASE = 64'h4010_0000_0000_0000;
    localparam logic [63:0] S_BASE = 64'h0000_0001_0000_0000;

    typedef struct {
        logic          flush;
        logic          stb;
        logic [63:0]   din;
        logic          ack;
        logic          e_iack;
        logic          e_ostb;
        logic [CW-1:0] e_cnt;
        logic [CW-1:0] e_max;
        logic          chk_d;
        logic [63:0]   e_d;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [CW-1:0] count;
    logic [CW-1:0] max_count;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];

    stream_fifo_if #(.WIDTH(WIDTH)) bus ();

    stream_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .bus       (bus.slave),
        .count     (count),
        .max_count (max_count)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic fl, input logic stb, input logic [63:0] din,
                                input logic ack, input logic e_iack, input logic e_ostb,
                                input int e_cnt, input int e_max,
                                input logic chk_d, input logic [63:0] e_d);
        vec_t v;
        v.flush  = fl;
        v.stb    = stb;
        v.din    = din;
        v.ack    = ack;
        v.e_iack = e_iack;
        v.e_ostb = e_ostb;
        v.e_cnt  = CW'(e_cnt);
        v.e_max  = CW'(e_max);
        v.chk_d  = chk_d;
        v.e_d    = e_d;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " input_a_ack"}, 64'(bus.input_a_ack), 64'd1);
        check({tag, " output_z_stb"}, 64'(bus.output_z_stb), 64'd0);
        check({tag, " count"}, 64'(count), 64'd0);
        check({tag, " max_count"}, 64'(max_count), 64'd0);
    endtask

    task automatic drive(input logic fl, input logic stb, input logic [63:0] din, input logic ack);
        flush            = fl;
        bus.input_a_stb  = stb;
        bus.input_a      = din;
        bus.output_z_ack = ack;
    endtask

    initial begin
        // Outputs are checked just before each rising edge, so every expected
        // value describes the state left by the previous edges plus the
        // combinational effect of flush on the handshake flags.

        // Fill: 10 offered words, only 8 accepted.
        for (int i = 0; i < 10; i++) begin
            add(0, 1, D_BASE + 64'(i), 0, i < 8, i > 0, (i < 8) ? i : 8, (i < 8) ? i : 8,
                i > 0, D_BASE);
        end
        // Drain with ack held: words 0..7 on consecutive cycles, then empty.
        for (int j = 0; j < 9; j++) begin
            add(0, 0, '0, 1, j > 0, j < 8, 8 - j, 8, j < 8, D_BASE + 64'(j));
        end
        // Fill again (pointers wrap back to 0 after the first 8 pushes).
        for (int i = 0; i < 8; i++) begin
            add(0, 1, E_BASE + 64'(i), 0, 1, i > 0, i, 8, i > 0, E_BASE);
        end
        // Full with pop and stb together: only the pop happens.
        add(0, 1, 64'hBAD0, 1, 0, 1, 8, 8, 1, E_BASE);
        add(0, 0, '0, 0, 1, 1, 7, 8, 1, E_BASE + 64'd1);
        // Flush with stb and ack both high masks both handshakes.
        add(1, 1, 64'hBAD1, 1, 0, 0, 7, 8, 0, '0);
        add(0, 0, '0, 0, 1, 0, 0, 0, 0, '0);
        // Load 5 words, then flush while stb and ack are high.
        for (int i = 0; i < 5; i++) begin
            add(0, 1, F_BASE + 64'(i), 0, 1, i > 0, i, i, i > 0, F_BASE);
        end
        add(1, 1, 64'hBAD2, 1, 0, 0, 5, 5, 0, '0);
        // 0xDEAD after the flush must be the next word out.
        add(0, 1, 64'hDEAD, 0, 1, 0, 0, 0, 0, '0);
        add(0, 0, '0, 1, 1, 1, 1, 1, 1, 64'hDEAD);
        add(0, 0, '0, 0, 1, 0, 0, 1, 0, '0);
        // Clear the peak statistic, then stream 100 words with both sides high.
        add(1, 0, '0, 0, 0, 0, 0, 1, 0, '0);
        for (int k = 0; k < 100; k++) begin
            add(0, 1, S_BASE + 64'(k), 1, 1, k > 0, (k > 0) ? 1 : 0, (k > 0) ? 1 : 0,
                k > 0, S_BASE + 64'(k - 1));
        end
        add(0, 0, '0, 1, 1, 1, 1, 1, 1, S_BASE + 64'd99);
        add(0, 0, '0, 0, 1, 0, 0, 1, 0, '0);

        // Reset held low for 3 cycles: idle flags throughout.
        drive(0, 0, '0, 0);
        rst = 1'b0;
        #1;
        check_idle("reset t0");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle($sformatf("reset cyc%0d", c));
        end
        rst = 1'b1;
        #1;
        check_idle("after release");

        // Apply the vector table.
        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].flush, vecs[n].stb, vecs[n].din, vecs[n].ack);
            #1;
            check($sformatf("v%0d input_a_ack", n), 64'(bus.input_a_ack), 64'(vecs[n].e_iack));
            check($sformatf("v%0d output_z_stb", n), 64'(bus.output_z_stb), 64'(vecs[n].e_ostb));
            check($sformatf("v%0d count", n), 64'(count), 64'(vecs[n].e_cnt));
            check($sformatf("v%0d max_count", n), 64'(max_count), 64'(vecs[n].e_max));
            if (vecs[n].chk_d) begin
                check($sformatf("v%0d output_z", n), bus.output_z, vecs[n].e_d);
            end
        end

        // Reset mid-transfer: push 3 words, assert reset between edges.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(0, 1, 64'hAAAA_0000 + 64'(i), 0);
        end
        @(negedge clk);
        drive(0, 0, '0, 0);
        #1;
        check("midrst pre count", 64'(count), 64'd3);
        #1;
        rst = 1'b0;
        #1;
        check_idle("midrst async");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle("midrst release");
        drive(0, 1, 64'h1234, 1);
        @(negedge clk);
        drive(0, 0, '0, 0);
        #1;
        check("midrst new stb", 64'(bus.output_z_stb), 64'd1);
        check("midrst new data", bus.output_z, 64'h1234);
        check("midrst new count", 64'(count), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
